alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/operation interface.
- Accepts decoded instruction fields from the ID stage and maps ALUOp/funct to the 4-bit ALU operation code.
- Selects and extends operands, then holds the result in a 2-entry skid buffer that presents aluSrc1/aluSrc2/ALU_operation_i to the EX-stage ALU.
- Uses a valid/ready handshake on both sides and supports a flush.

Parameters:
- DW, 32, operand width.
- RW, 5, register address width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- in_valid_i  input  1  ID presents an instruction.
- in_ready_o  output  1  stage can accept; high when fewer than 2 entries are held.
- aluop_i  input  3  main-control ALU class.
- funct_i  input  6  R-type funct field.
- alusrc_i  input  1  1 = immediate selected as source 2.
- rs_addr_i  input  RW  source register address.
- rt_addr_i  input  RW  source register address.
- rs_data_i  input  DW  source register data.
- rt_data_i  input  DW  source register data.
- imm_i  input  16  instruction immediate.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  EX accepts the head entry.
- aluSrc1_o  output  DW  operand 1 to ALU.
- aluSrc2_o  output  DW  operand 2 to ALU.
- ALU_operation_o  output  4  ALU operation code.
- illegal_o  output  1  head entry carries an unrecognised op.
- wb_we_i  input  1  writeback enable; used only with ALU_ISSUE_FWD_EN.
- wb_addr_i  input  RW  writeback register address.
- wb_data_i  input  DW  writeback data.

Behaviour:
- Operation codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, LTZ=9, NOR=12. Unrecognised op gives code 15 with illegal=1; the ALU outputs 0 for code 15.
- aluop mapping: 000 ADD (lw/sw); 001 SUB (beq); 010 R-type via funct; 011 SLT (slti); 100 LTZ (bltz); 101 OR (ori); 110 AND (andi); 111 illegal.
- funct mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT. Any other funct gives code 15 with illegal=1.
- Immediate: zero-extended for aluop 101/110, sign-extended otherwise.
- aluSrc2 = alusrc_i ? extended imm : rt_data. aluSrc1 = rs_data.
- Capture occurs when in_valid_i && in_ready_o. Decode is combinational; operands and code are registered at capture.
- Latency: 1 cycle from capture to out_valid_o when the buffer is empty.
- Buffer: 2-entry FIFO with head/tail pointers and a 2-bit count.
  - Outputs always reflect the head entry.
  - Pop occurs when out_valid_o && out_ready_i.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push is blocked when count=2 (in_ready_o=0). Pop is ignored when count=0.
- in_ready_o = (count<2), registered-state based; no combinational path from out_ready_i.
- Pointer wrap: 1 -> 0.
- States by count: EMPTY(0), ONE(1), FULL(2). Transitions follow push/pop as above.
- flush_i: next cycle count=0 and out_valid_o=0; any same-cycle push is dropped. flush has priority over push and pop.
- Reset (rst_n low, async): count=0, pointers=0, out_valid_o=0, aluSrc1_o=0, aluSrc2_o=0, ALU_operation_o=0, illegal_o=0, in_ready_o=1.
- Reset asserted mid-transfer drops all entries immediately; there is no partial state.
- Output data is held stable while out_valid_o && !out_ready_i.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- When defined, at capture:
  - If wb_we_i && wb_addr_i!=0 && wb_addr_i==rs_addr_i, wb_data_i replaces rs_data_i.
  - Same rule for rt_addr_i/rt_data_i, before alusrc selection.
- When undefined: wb_* ports exist but are ignored; register data is used as-is.

Test Plan:
- Reset then single push: aluop=010, funct=0x22, rs=7, rt=3 -> next cycle out_valid=1, code=6, src1=7, src2=3.
- Immediate extension: andi imm=0xFFFF -> src2=0x0000FFFF, code=0; slti imm=0xFFFF -> src2=0xFFFFFFFF, code=7.
- Backpressure: out_ready=0, push A, B, C -> in_ready=0 after B, C not captured; release -> A then B popped in order, with outputs stable while stalled.
- Illegal/flush: funct=0x3F -> code=15, illegal=1; flush with count=2 and simultaneous push -> next cycle out_valid=0, in_ready=1.
- ALU_ISSUE_FWD_EN: wb_we=1, wb_addr=rs_addr=5, wb_data=0x55, rs_data=0x11 -> src1=0x55. With wb_addr=0 -> src1=0x11. Without the macro -> src1=0x11.
- Async reset asserted mid-stall with count=2 -> out_valid=0 immediately, all outputs 0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ID-to-ALU issue interface: instruction fields in, operands/op code out, plus flush and writeback.
// The master is the ID/EX side; the slave is alu_issue_stage.
`timescale 1ns/1ps
interface alu_issue_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) ();
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [2:0]    aluop_i;
  logic [5:0]    funct_i;
  logic          alusrc_i;
  logic [RW-1:0] rs_addr_i;
  logic [RW-1:0] rt_addr_i;
  logic [DW-1:0] rs_data_i;
  logic [DW-1:0] rt_data_i;
  logic [15:0]   imm_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] aluSrc1_o;
  logic [DW-1:0] aluSrc2_o;
  logic [3:0]    ALU_operation_o;
  logic          illegal_o;
  logic          wb_we_i;
  logic [RW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;

  modport master (
    output flush_i, in_valid_i, aluop_i, funct_i, alusrc_i, rs_addr_i, rt_addr_i,
           rs_data_i, rt_data_i, imm_i, out_ready_i, wb_we_i, wb_addr_i, wb_data_i,
    input  in_ready_o, out_valid_o, aluSrc1_o, aluSrc2_o, ALU_operation_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, aluop_i, funct_i, alusrc_i, rs_addr_i, rt_addr_i,
           rs_data_i, rt_data_i, imm_i, out_ready_i, wb_we_i, wb_addr_i, wb_data_i,
    output in_ready_o, out_valid_o, aluSrc1_o, aluSrc2_o, ALU_operation_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct, selects/extends operands, buffers them in a 2-entry skid FIFO.
// Optional macro ALU_ISSUE_FWD_EN forwards writeback data onto rs/rt at capture.
`timescale 1ns/1ps
module alu_issue_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic               clk_i,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LTZ = 4'd9;
  localparam logic [3:0] OP_NOR = 4'd12;
  localparam logic [3:0] OP_ILL = 4'd15;
  localparam int unsigned EXT_W = DW - 16;

  typedef struct packed {
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [3:0]    op;
    logic          ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic          out_valid_q, in_ready_q;
  entry_t        mem_q [2];
  entry_t        out_q, head_entry_d;

  logic [3:0]    op_c;
  logic          ill_c;
  logic          zext_c;
  logic [DW-1:0] imm_ext_c;
  logic [DW-1:0] rs_val_c, rt_val_c;
  entry_t        new_entry_c;
  logic          push_c, pop_c, wr_en_c;

  // Operation decode and immediate extension
  always_comb begin
    op_c   = OP_ILL;
    ill_c  = 1'b1;
    zext_c = 1'b0;
    case (bus.aluop_i)
      3'b000: begin op_c = OP_ADD; ill_c = 1'b0; end
      3'b001: begin op_c = OP_SUB; ill_c = 1'b0; end
      3'b010: begin
        case (bus.funct_i)
          6'h20: begin op_c = OP_ADD; ill_c = 1'b0; end
          6'h22: begin op_c = OP_SUB; ill_c = 1'b0; end
          6'h24: begin op_c = OP_AND; ill_c = 1'b0; end
          6'h25: begin op_c = OP_OR;  ill_c = 1'b0; end
          6'h27: begin op_c = OP_NOR; ill_c = 1'b0; end
          6'h2A: begin op_c = OP_SLT; ill_c = 1'b0; end
          default: ;
        endcase
      end
      3'b011: begin op_c = OP_SLT; ill_c = 1'b0; end
      3'b100: begin op_c = OP_LTZ; ill_c = 1'b0; end
      3'b101: begin op_c = OP_OR;  ill_c = 1'b0; zext_c = 1'b1; end
      3'b110: begin op_c = OP_AND; ill_c = 1'b0; zext_c = 1'b1; end
      default: ;
    endcase
    imm_ext_c = zext_c ? {{EXT_W{1'b0}}, bus.imm_i}
                       : {{EXT_W{bus.imm_i[15]}}, bus.imm_i};
  end

`ifdef ALU_ISSUE_FWD_EN
  // Writeback bypass onto source registers; r0 never forwards
  always_comb begin
    rs_val_c = bus.rs_data_i;
    rt_val_c = bus.rt_data_i;
    if (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.rs_addr_i))
      rs_val_c = bus.wb_data_i;
    if (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.rt_addr_i))
      rt_val_c = bus.wb_data_i;
  end
`else
  logic unused_fwd_c;
  assign rs_val_c    = bus.rs_data_i;
  assign rt_val_c    = bus.rt_data_i;
  assign unused_fwd_c = ^{bus.wb_we_i, bus.wb_addr_i, bus.wb_data_i,
                          bus.rs_addr_i, bus.rt_addr_i};
`endif

  always_comb begin
    new_entry_c.src1 = rs_val_c;
    new_entry_c.src2 = bus.alusrc_i ? imm_ext_c : rt_val_c;
    new_entry_c.op   = op_c;
    new_entry_c.ill  = ill_c;
  end

  assign push_c = bus.in_valid_i && in_ready_q;
  assign pop_c  = out_valid_q && bus.out_ready_i;

  // Occupancy FSM and pointer update; flush overrides push and pop
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    wr_en_c      = 1'b0;
    if (bus.flush_i) begin
      state_d = EMPTY;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      wr_en_c = push_c;
      if (push_c) tail_d = ~tail_q;
      if (pop_c)  head_d = ~head_q;
      case (state_q)
        EMPTY:   if (push_c) state_d = ONE;
        ONE: begin
          if (push_c && !pop_c)      state_d = FULL;
          else if (!push_c && pop_c) state_d = EMPTY;
        end
        FULL:    if (pop_c) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
    // Next head: a push landing in the new head slot bypasses the array
    head_entry_d = (wr_en_c && (tail_q == head_d)) ? new_entry_c : mem_q[head_d];
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
      out_q       <= head_entry_d;
      if (wr_en_c) mem_q[tail_q] <= new_entry_c;
    end
  end

  assign bus.in_ready_o      = in_ready_q;
  assign bus.out_valid_o     = out_valid_q;
  assign bus.aluSrc1_o       = out_q.src1;
  assign bus.aluSrc2_o       = out_q.src2;
  assign bus.ALU_operation_o = out_q.op;
  assign bus.illegal_o       = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus a randomized handshake phase.
`timescale 1ns/1ps
module tb_alu_issue_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DW(DW), .RW(RW)) bus ();
  alu_issue_stage #(.DW(DW), .RW(RW)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode from the current input fields
  function automatic exp_t model();
    exp_t        e;
    logic        zx;
    logic [31:0] rs, rt, ext;
    e.op = 4'd15; e.ill = 1'b1; zx = 1'b0;
    case (bus.aluop_i)
      3'd0: begin e.op = 4'd2; e.ill = 1'b0; end
      3'd1: begin e.op = 4'd6; e.ill = 1'b0; end
      3'd2: begin
        e.ill = 1'b0;
        case (bus.funct_i)
          6'h20: e.op = 4'd2;
          6'h22: e.op = 4'd6;
          6'h24: e.op = 4'd0;
          6'h25: e.op = 4'd1;
          6'h27: e.op = 4'd12;
          6'h2A: e.op = 4'd7;
          default: begin e.op = 4'd15; e.ill = 1'b1; end
        endcase
      end
      3'd3: begin e.op = 4'd7; e.ill = 1'b0; end
      3'd4: begin e.op = 4'd9; e.ill = 1'b0; end
      3'd5: begin e.op = 4'd1; e.ill = 1'b0; zx = 1'b1; end
      3'd6: begin e.op = 4'd0; e.ill = 1'b0; zx = 1'b1; end
      default: ;
    endcase
    ext = zx ? {16'h0000, bus.imm_i} : {{16{bus.imm_i[15]}}, bus.imm_i};
    rs = bus.rs_data_i;
    rt = bus.rt_data_i;
    if (FWD && bus.wb_we_i && bus.wb_addr_i != 5'd0) begin
      if (bus.wb_addr_i == bus.rs_addr_i) rs = bus.wb_data_i;
      if (bus.wb_addr_i == bus.rt_addr_i) rt = bus.wb_data_i;
    end
    e.s1 = rs;
    e.s2 = bus.alusrc_i ? ext : rt;
    return e;
  endfunction

  // Scoreboard: inputs change only just after posedge, so negedge sees a settled handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.flush_i) sb.delete();
      else begin
        if (bus.out_valid_o && bus.out_ready_i) begin
          if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("sb_src1", 64'(bus.aluSrc1_o), 64'(e.s1));
            chk("sb_src2", 64'(bus.aluSrc2_o), 64'(e.s2));
            chk("sb_op",   64'(bus.ALU_operation_o), 64'(e.op));
            chk("sb_ill",  64'(bus.illegal_o), 64'(e.ill));
          end
        end
        if (bus.in_valid_i && bus.in_ready_o) sb.push_back(model());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] aluop, input logic [5:0] funct, input logic src,
                        input logic [4:0] rsa, input logic [4:0] rta,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    bus.aluop_i   = aluop;
    bus.funct_i   = funct;
    bus.alusrc_i  = src;
    bus.rs_addr_i = rsa;
    bus.rt_addr_i = rta;
    bus.rs_data_i = rsd;
    bus.rt_data_i = rtd;
    bus.imm_i     = imm;
    bus.in_valid_i = 1'b1;
  endtask

  task automatic push(input logic [2:0] aluop, input logic [5:0] funct, input logic src,
                      input logic [4:0] rsa, input logic [4:0] rta,
                      input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    set_in(aluop, funct, src, rsa, rta, rsd, rtd, imm);
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [3:0] op, input logic ill);
    chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
    chk({tag, "_src1"},  64'(bus.aluSrc1_o), 64'(s1));
    chk({tag, "_src2"},  64'(bus.aluSrc2_o), 64'(s2));
    chk({tag, "_op"},    64'(bus.ALU_operation_o), 64'(op));
    chk({tag, "_ill"},   64'(bus.illegal_o), 64'(ill));
  endtask

  logic [2:0] tbl_op [12] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
  logic [5:0] tbl_fn [12] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.aluop_i = '0; bus.funct_i = '0;
    bus.alusrc_i = 1'b0; bus.rs_addr_i = '0; bus.rt_addr_i = '0; bus.rs_data_i = '0;
    bus.rt_data_i = '0; bus.imm_i = '0; bus.out_ready_i = 1'b1;
    bus.wb_we_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
    #12;
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst_src1",  64'(bus.aluSrc1_o), 64'd0);
    chk("rst_src2",  64'(bus.aluSrc2_o), 64'd0);
    chk("rst_op",    64'(bus.ALU_operation_o), 64'd0);
    chk("rst_ill",   64'(bus.illegal_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Single R-type SUB: visible one cycle after capture
    push(3'b010, 6'h22, 1'b0, 5'd1, 5'd2, 32'd7, 32'd3, 16'h0);
    chk_head("sub", 32'd7, 32'd3, 4'd6, 1'b0);

    push(3'b110, 6'h00, 1'b1, 5'd1, 5'd2, 32'h1234, 32'h9, 16'hFFFF);
    chk_head("andi", 32'h1234, 32'h0000FFFF, 4'd0, 1'b0);
    push(3'b011, 6'h00, 1'b1, 5'd1, 5'd2, 32'h1234, 32'h9, 16'hFFFF);
    chk_head("slti", 32'h1234, 32'hFFFFFFFF, 4'd7, 1'b0);
    push(3'b010, 6'h3F, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 16'h0);
    chk_head("bad_funct", 32'h1, 32'h2, 4'd15, 1'b1);

    for (int i = 0; i < 12; i++)
      push(tbl_op[i], tbl_fn[i], 1'(i % 2), 5'd1, 5'd2, $urandom, $urandom, 16'($urandom));
    tick();
    tick();

    // Backpressure: A, B fill the buffer, C is refused, head stays A
    bus.out_ready_i = 1'b0;
    push(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'hA1, 32'hA2, 16'h0);
    push(3'b001, 6'h0, 1'b0, 5'd1, 5'd2, 32'hB1, 32'hB2, 16'h0);
    chk("bp_ready_full", 64'(bus.in_ready_o), 64'd0);
    set_in(3'b101, 6'h0, 1'b1, 5'd1, 5'd2, 32'hC1, 32'hC2, 16'h8001);
    tick();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_head("bp_hold", 32'hA1, 32'hA2, 4'd2, 1'b0);
      tick();
    end
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    chk("bp_drained", 64'(bus.out_valid_o), 64'd0);
    chk("bp_ready", 64'(bus.in_ready_o), 64'd1);

    // Flush with a full buffer and a simultaneous push attempt
    bus.out_ready_i = 1'b0;
    push(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'hD1, 32'hD2, 16'h0);
    push(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'hE1, 32'hE2, 16'h0);
    set_in(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'hF1, 32'hF2, 16'h0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk("flush_full_valid", 64'(bus.out_valid_o), 64'd0);
    chk("flush_full_ready", 64'(bus.in_ready_o), 64'd1);
    push(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'h11, 32'h12, 16'h0);
    set_in(3'b000, 6'h0, 1'b0, 5'd1, 5'd2, 32'h21, 32'h22, 16'h0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    chk("flush_one_valid", 64'(bus.out_valid_o), 64'd0);
    tick();
    chk("flush_push_dropped", 64'(bus.out_valid_o), 64'd0);
    bus.out_ready_i = 1'b1;

    // Writeback forwarding
    bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'h55;
    push(3'b010, 6'h20, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 16'h0);
    chk_head("fwd_rs", FWD ? 32'h55 : 32'h11, 32'h22, 4'd2, 1'b0);
    bus.wb_addr_i = 5'd6;
    push(3'b010, 6'h20, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 16'h0);
    chk_head("fwd_rt", 32'h11, FWD ? 32'h55 : 32'h22, 4'd2, 1'b0);
    push(3'b000, 6'h00, 1'b1, 5'd5, 5'd6, 32'h11, 32'h22, 16'h0040);
    chk_head("fwd_imm", 32'h11, 32'h40, 4'd2, 1'b0);
    bus.wb_addr_i = 5'd0;
    push(3'b010, 6'h20, 1'b0, 5'd0, 5'd0, 32'h11, 32'h22, 16'h0);
    chk_head("fwd_r0", 32'h11, 32'h22, 4'd2, 1'b0);
    bus.wb_we_i = 1'b0;
    tick();

    // Async reset while stalled with two entries
    bus.out_ready_i = 1'b0;
    push(3'b001, 6'h0, 1'b0, 5'd1, 5'd2, 32'h77, 32'h88, 16'h0);
    push(3'b001, 6'h0, 1'b0, 5'd1, 5'd2, 32'h99, 32'hAA, 16'h0);
    chk("arst_pre_valid", 64'(bus.out_valid_o), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("arst_ready", 64'(bus.in_ready_o), 64'd1);
    chk("arst_src1",  64'(bus.aluSrc1_o), 64'd0);
    chk("arst_src2",  64'(bus.aluSrc2_o), 64'd0);
    chk("arst_op",    64'(bus.ALU_operation_o), 64'd0);
    chk("arst_ill",   64'(bus.illegal_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.aluop_i   = 3'($urandom);
      bus.funct_i   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(6'h20 + 6'($urandom_range(0, 10)));
      bus.alusrc_i  = 1'($urandom);
      bus.rs_addr_i = 5'($urandom_range(0, 7));
      bus.rt_addr_i = 5'($urandom_range(0, 7));
      bus.rs_data_i = $urandom;
      bus.rt_data_i = $urandom;
      bus.imm_i     = 16'($urandom);
      bus.wb_we_i   = 1'($urandom);
      bus.wb_addr_i = 5'($urandom_range(0, 7));
      bus.wb_data_i = $urandom;
      bus.in_valid_i  = 1'($urandom);
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i     = ($urandom_range(0, 31) == 0);
      tick();
    end
    bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_valid", 64'(bus.out_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
